// File: rtl/sdram_cmd_resp.sv
// sdram_cmd_resp: block-RAM backed responder for the arbitrated SDRAM command port.
// Latency: ack after ACK_DLY un-stalled cycles following the command cycle; read beat 0 at ack+RD_LAT.
// Backpressure: one command outstanding; stall freezes the ack countdown only, bursts in flight run on.
//
// Ports:
//   sdramclk, rst_sdramclk         clock and synchronous active-high reset
//   sdram_cmd/_cmd_en/_addr/_cmd_len  command request (0 = read, 1 = write), held until sdram_ack
//   sdram_wdata, sdram_mask        write beats; mask bit i = 1 leaves byte i untouched
//   sdram_ack                      one-cycle acceptance pulse
//   sdram_rdata, sdram_rvalid      read beats, rdata holds its value between beats
//   stall                          holds off acks to emulate refresh/busy periods
module sdram_cmd_resp #(
  parameter int AW      = 10,
  parameter int ACK_DLY = 2,
  parameter int RD_LAT  = 3
) (
  input  logic        sdramclk,
  input  logic        rst_sdramclk,
  input  logic        sdram_cmd,
  input  logic        sdram_cmd_en,
  input  logic [22:0] sdram_addr,
  input  logic [3:0]  sdram_cmd_len,
  input  logic [31:0] sdram_wdata,
  input  logic [3:0]  sdram_mask,
  output logic        sdram_ack,
  output logic [31:0] sdram_rdata,
  output logic        sdram_rvalid,
  input  logic        stall
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    WBURST,
    RLAT,
    RBURST,
    GAP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            cmd_r;
  logic [3:0]      len_r;
  logic [3:0]      cnt;
  logic [3:0]      cnt_nxt;
  logic [AW-1:0]   cur_addr;
  logic            latch;
  logic            ack;
  logic            ram_we;
  logic            ram_re;
  logic [31:0]     mem [DEPTH];

  // Address bits above AW are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^sdram_addr[22:AW];

  // cnt is shared: ack countdown in WAIT, latency countdown in RLAT,
  // and remaining beats in WBURST/RBURST.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    latch     = 1'b0;
    ack       = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    case (state)
      IDLE: begin
        if (sdram_cmd_en) begin
          latch     = 1'b1;
          cnt_nxt   = 4'(ACK_DLY - 1);
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (!stall) begin
          if (cnt == 4'd0) begin
            ack = 1'b1;
            if (cmd_r) begin
              // Beat 0 is written in the ack cycle itself.
              ram_we    = 1'b1;
              cnt_nxt   = len_r;
              state_nxt = (len_r == 4'd0) ? GAP : WBURST;
            end else begin
              // RLAT spans RD_LAT-1 cycles; its last cycle issues the beat-0 read.
              cnt_nxt   = 4'(RD_LAT - 2);
              state_nxt = RLAT;
            end
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
      end
      WBURST: begin
        ram_we  = 1'b1;
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = GAP;
        end
      end
      RLAT: begin
        if (cnt == 4'd0) begin
          ram_re    = 1'b1;
          cnt_nxt   = len_r;
          state_nxt = RBURST;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RBURST: begin
        // Each cycle here presents one beat; reads are issued one cycle ahead,
        // so the final beat's cycle issues nothing.
        if (cnt != 4'd0) begin
          ram_re  = 1'b1;
          cnt_nxt = cnt - 4'd1;
        end else begin
          state_nxt = GAP;
        end
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign sdram_ack = ack;

  always_ff @(posedge sdramclk) begin
    if (rst_sdramclk) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      cmd_r        <= 1'b0;
      len_r        <= 4'd0;
      cur_addr     <= '0;
      sdram_rvalid <= 1'b0;
      sdram_rdata  <= 32'd0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      sdram_rvalid <= ram_re;
      if (latch) begin
        cmd_r    <= sdram_cmd;
        len_r    <= sdram_cmd_len;
        cur_addr <= sdram_addr[AW-1:0];
      end else if (ram_we || ram_re) begin
        // Wraps modulo 2^AW at the top of the RAM.
        cur_addr <= cur_addr + AW'(1);
      end
      if (ram_re) begin
        sdram_rdata <= mem[cur_addr];
      end
    end
  end

  // RAM contents survive reset; a beat coinciding with reset is dropped.
  always_ff @(posedge sdramclk) begin
    if (ram_we && !rst_sdramclk) begin
      for (int i = 0; i < 4; i++) begin
        if (!sdram_mask[i]) begin
          mem[cur_addr][8*i +: 8] <= sdram_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_cmd_resp.sv
module tb_sdram_cmd_resp;

  localparam int AW      = 10;
  localparam int DEPTH   = 1 << AW;
  localparam int ACK_DLY = 2;
  localparam int RD_LAT  = 3;

  logic        sdramclk;
  logic        rst_sdramclk;
  logic        sdram_cmd;
  logic        sdram_cmd_en;
  logic [22:0] sdram_addr;
  logic [3:0]  sdram_cmd_len;
  logic [31:0] sdram_wdata;
  logic [3:0]  sdram_mask;
  logic        sdram_ack;
  logic [31:0] sdram_rdata;
  logic        sdram_rvalid;
  logic        stall;

  sdram_cmd_resp #(.AW(AW), .ACK_DLY(ACK_DLY), .RD_LAT(RD_LAT)) dut (
    .sdramclk      (sdramclk),
    .rst_sdramclk  (rst_sdramclk),
    .sdram_cmd     (sdram_cmd),
    .sdram_cmd_en  (sdram_cmd_en),
    .sdram_addr    (sdram_addr),
    .sdram_cmd_len (sdram_cmd_len),
    .sdram_wdata   (sdram_wdata),
    .sdram_mask    (sdram_mask),
    .sdram_ack     (sdram_ack),
    .sdram_rdata   (sdram_rdata),
    .sdram_rvalid  (sdram_rvalid),
    .stall         (stall)
  );

  initial sdramclk = 1'b0;
  always #5 sdramclk = ~sdramclk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge sdramclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model: schedule of events per cycle -------------
  logic [31:0] mmem [DEPTH];
  bit          rv_at [int];
  logic [31:0] rd_at [int];
  logic [31:0] last_rd;
  int  m_mode = 0;   // 0 idle, 1 waiting for ack, 2 busy with burst
  int  m_need, m_free, m_wleft, m_wa, m_addr, m_len;
  bit  m_wr;
  bit  m_valid = 0;

  always @(negedge sdramclk) begin
    logic        e_ack;
    logic        e_rv;
    logic [31:0] e_rd;
    e_ack = 1'b0;
    e_rv  = rv_at.exists(cyc);
    e_rd  = e_rv ? rd_at[cyc] : last_rd;
    if (m_mode == 2 && cyc >= m_free) m_mode = 0;
    if (m_mode == 0) begin
      if (sdram_cmd_en === 1'b1) begin
        m_wr   = sdram_cmd;
        m_addr = int'(sdram_addr[AW-1:0]);
        m_len  = int'(sdram_cmd_len);
        m_need = ACK_DLY;
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (stall === 1'b0) begin
        m_need--;
        if (m_need == 0) begin
          e_ack  = 1'b1;
          m_mode = 2;
          if (m_wr) begin
            m_wleft = m_len + 1;
            m_wa    = m_addr;
            m_free  = cyc + m_len + 2;
          end else begin
            for (int k = 0; k <= m_len; k++) begin
              rv_at[cyc + RD_LAT + k] = 1'b1;
              rd_at[cyc + RD_LAT + k] = mmem[(m_addr + k) % DEPTH];
            end
            m_free = cyc + RD_LAT + m_len + 2;
          end
        end
      end
    end
    if (m_wleft > 0 && !rst_sdramclk) begin
      for (int b = 0; b < 4; b++)
        if (!sdram_mask[b]) mmem[m_wa][8*b +: 8] = sdram_wdata[8*b +: 8];
      m_wa = (m_wa + 1) % DEPTH;
      m_wleft--;
    end
    if (m_valid) begin
      chk("ack", {31'd0, sdram_ack}, {31'd0, e_ack});
      chk("rvalid", {31'd0, sdram_rvalid}, {31'd0, e_rv});
      chk("rdata", sdram_rdata, e_rd);
    end
    last_rd = e_rd;
    if (rst_sdramclk) begin
      m_mode  = 0;
      m_wleft = 0;
      rv_at.delete();
      rd_at.delete();
      last_rd = 32'd0;
      m_valid = 1;
    end
  end

  // ---------------- observation for literal checks ----------------
  logic [31:0] cap_q [$];
  int          capc_q [$];
  int          ack_count = 0;
  always @(negedge sdramclk) begin
    if (sdram_rvalid === 1'b1) begin
      cap_q.push_back(sdram_rdata);
      capc_q.push_back(cyc);
    end
    if (sdram_ack === 1'b1) ack_count++;
  end

  // ---------------- stimulus helpers (entered and left just after a posedge) -----
  logic [31:0] wbuf [16];
  logic [3:0]  mbuf [16];
  logic [31:0] expbuf [16];
  int ack_c, start_c, ack_c2, start_c2;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sdramclk);
    #1;
  endtask

  task automatic do_cmd(input bit wr, input logic [22:0] a, input logic [3:0] l,
                        input bit keep, output int ac, output int sc);
    int budget;
    sdram_cmd     = wr;
    sdram_addr    = a;
    sdram_cmd_len = l;
    sdram_wdata   = wbuf[0];
    sdram_mask    = mbuf[0];
    sdram_cmd_en  = 1'b1;
    sc = cyc;
    ac = -1;
    budget = 0;
    while (ac < 0 && budget < 200) begin
      @(negedge sdramclk);
      if (sdram_ack === 1'b1) ac = cyc;
      budget++;
      @(posedge sdramclk);
      #1;
    end
    if (ac < 0) begin
      checks++;
      fails++;
      $display("FAIL ack_timeout: no ack within %0d cycles, expected one", budget);
    end
    if (!keep) sdram_cmd_en = 1'b0;
    if (wr) begin
      for (int k = 1; k <= int'(l); k++) begin
        sdram_wdata = wbuf[k];
        sdram_mask  = mbuf[k];
        @(posedge sdramclk);
        #1;
      end
    end
  endtask

  task automatic do_write(input logic [22:0] a, input int l);
    do_cmd(1'b1, a, 4'(l), 1'b0, ack_c, start_c);
    wait_cyc(2);
  endtask

  task automatic do_read(input logic [22:0] a, input int l, input string nm);
    cap_q.delete();
    capc_q.delete();
    do_cmd(1'b0, a, 4'(l), 1'b0, ack_c, start_c);
    wait_cyc(RD_LAT + l + 4);
    chk({nm, "_beats"}, cap_q.size(), l + 1);
    for (int k = 0; k <= l; k++)
      if (k < cap_q.size()) chk($sformatf("%s_d%0d", nm, k), cap_q[k], expbuf[k]);
    if (cap_q.size() > 0) chk({nm, "_lat"}, capc_q[0] - ack_c, RD_LAT);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack0, b;
    rst_sdramclk = 1'b1;
    sdram_cmd = 0; sdram_cmd_en = 0; sdram_addr = 0; sdram_cmd_len = 0;
    sdram_wdata = 0; sdram_mask = 0; stall = 0;
    for (int k = 0; k < 16; k++) begin wbuf[k] = 0; mbuf[k] = 0; expbuf[k] = 0; end
    repeat (3) @(posedge sdramclk);
    #1;
    chk("reset_ack", {31'd0, sdram_ack}, 32'd0);
    chk("reset_rvalid", {31'd0, sdram_rvalid}, 32'd0);
    chk("reset_rdata", sdram_rdata, 32'd0);
    rst_sdramclk = 1'b0;
    wait_cyc(2);

    // basic write then read of 4 beats
    for (int k = 0; k < 4; k++) wbuf[k] = 32'hA0 + k;
    do_write(23'h000010, 3);
    chk("wr_ack_cycle", ack_c - start_c, 32'd2);
    for (int k = 0; k < 4; k++) expbuf[k] = 32'hA0 + k;
    do_read(23'h000010, 3, "rd_a0");
    if (capc_q.size() == 4) chk("rd_a0_contig", capc_q[3] - capc_q[0], 32'd3);

    // byte masks
    wbuf[0] = 32'hFFFFFFFF; mbuf[0] = 4'b0000;
    do_write(23'h20, 0);
    wbuf[0] = 32'h12345678; mbuf[0] = 4'b0101;
    do_write(23'h20, 0);
    mbuf[0] = 4'b0000;
    expbuf[0] = 32'h12FF56FF;
    do_read(23'h20, 0, "rd_mask");

    // back-to-back reads with cmd_en held high
    for (int k = 0; k < 16; k++) wbuf[k] = 32'h1000 + k;
    do_write(23'h100, 15);
    wbuf[0] = 32'hCAFE0200;
    do_write(23'h200, 0);
    cap_q.delete();
    capc_q.delete();
    ack0 = ack_count;
    do_cmd(1'b0, 23'h100, 4'd15, 1'b1, ack_c, start_c);
    do_cmd(1'b0, 23'h200, 4'd0, 1'b0, ack_c2, start_c2);
    wait_cyc(RD_LAT + 4);
    chk("b2b_acks", ack_count - ack0, 32'd2);
    chk("b2b_spacing", ack_c2 - ack_c, 32'd22);
    chk("b2b_beats", cap_q.size(), 32'd17);
    if (cap_q.size() == 17) begin
      chk("b2b_first", cap_q[0], 32'h1000);
      chk("b2b_last16", cap_q[15], 32'h100F);
      chk("b2b_second", cap_q[16], 32'hCAFE0200);
      chk("b2b_contig", capc_q[15] - capc_q[0], 32'd15);
      chk("b2b_gap", {31'd0, (capc_q[16] - capc_q[15]) >= 2}, 32'd1);
    end

    // wrap across the top address
    for (int k = 0; k < 4; k++) wbuf[k] = 32'hB0 + k;
    do_write(23'h3FE, 3);
    for (int k = 0; k < 4; k++) expbuf[k] = 32'hB0 + k;
    do_read(23'h3FE, 3, "rd_wrap");
    expbuf[0] = 32'hB2; expbuf[1] = 32'hB3;
    do_read(23'h400000, 1, "rd_wrap0");

    // stall holds off the ack
    stall = 1'b1;
    fork
      do_cmd(1'b0, 23'h10, 4'd0, 1'b0, ack_c, start_c);
      begin
        wait_cyc(10);
        stall = 1'b0;
      end
    join
    chk("stall_ack_cycle", ack_c - start_c, 32'd11);
    wait_cyc(RD_LAT + 4);

    // reset in the middle of a 16-beat read
    cap_q.delete();
    capc_q.delete();
    do_cmd(1'b0, 23'h100, 4'd15, 1'b0, ack_c, start_c);
    b = 0;
    while (cap_q.size() < 5 && b < 40) begin
      @(negedge sdramclk);
      #2;
      b++;
    end
    @(posedge sdramclk);
    #1;
    rst_sdramclk = 1'b1;
    @(posedge sdramclk);
    #1;
    rst_sdramclk = 1'b0;
    chk("rst_mid_rvalid", {31'd0, sdram_rvalid}, 32'd0);
    chk("rst_mid_rdata", sdram_rdata, 32'd0);
    wait_cyc(20);
    chk("rst_mid_beats", cap_q.size(), 32'd6);
    for (int k = 0; k < 4; k++) expbuf[k] = 32'h1000 + k;
    do_read(23'h100, 3, "rd_after_rst");

    wait_cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
